servo_sequencer: RTL and testbench
==================================

Name: servo_sequencer

Overview:
- Sequences one servo_controller through a programmed list of waypoints (angle, speed, dwell).
- Runs in the rotation_clk domain (20 Hz tick) and drives the controller's angle, speed and en inputs.
- Detects arrival by comparing the controller's live pulsewidth against the target pulsewidth.
- Supports one-shot or looped playback, abort, and a move-timeout fault.

Parameters:
- DEPTH, 16, number of waypoint entries (power of two).
- MOVE_TIMEOUT, 255, maximum rotation_clk ticks allowed in MOVE before a fault is raised.
- MIN_PW, 70, pulsewidth at 0 degrees, used in the arrival compare.

Ports:
- rotation_clk  in  1  sequencing clock (20 Hz).
- rst  in  1  reset; synchronous, active-high.
- start  in  1  level, sampled each tick; begins playback from entry 0.
- stop  in  1  level; aborts playback.
- loop_en  in  1  1 = wrap to entry 0 after the last entry.
- seq_len  in  5  number of active entries; valid range 1..DEPTH.
- wr_en  in  1  waypoint write strobe.
- wr_addr  in  log2(DEPTH)  entry to write.
- wr_angle  in  8  waypoint angle in degrees.
- wr_speed  in  4  waypoint speed.
- wr_dwell  in  8  hold time after arrival, in ticks.
- cur_pw  in  12  the controller's current pulsewidth.
- angle  out  8  angle driven to the controller.
- speed  out  4  speed driven to the controller.
- servo_en  out  1  PWM enable driven to the controller.
- busy  out  1  sequence active.
- step_idx  out  log2(DEPTH)  index of the current entry.
- done  out  1  one-tick pulse when a non-looped sequence completes.
- fault  out  1  sticky move-timeout flag.

Behaviour:
- Clock and reset: all logic is clocked on posedge rotation_clk with synchronous active-high rst.
- Reset values:
  - angle=0, speed=0, servo_en=0, busy=0, step_idx=0, done=0, fault=0, state=IDLE.
  - Waypoint memory is not reset.
- Writes:
  - Accepted only when busy=0; ignored while busy.
  - On store, angle>180 is saved as 180.
  - On store, speed>10 is saved as 10 and speed=0 is saved as 1.
  - Dwell is stored unchanged.
- Target pulsewidth: tgt = (angle*8)/9 + MIN_PW, computed in 12 bits with integer truncation (angle 90 -> 150, angle 180 -> 230).
- Effective length: L = min(seq_len, DEPTH).
- FSM states: IDLE, ISSUE, MOVE, DWELL, DONE, FAULT.
  - IDLE:
    - start=1, stop=0 and L!=0 -> ISSUE; step_idx<=0, busy<=1, servo_en<=1, fault<=0.
    - start with L=0 is ignored.
  - ISSUE (1 tick): angle<=mem.angle, speed<=mem.speed, move_cnt<=0 -> MOVE.
  - MOVE:
    - cur_pw==tgt -> DWELL, dwell_cnt<=mem.dwell.
    - Otherwise move_cnt++; when move_cnt reaches MOVE_TIMEOUT-1 -> FAULT.
  - DWELL:
    - dwell_cnt!=0: decrement.
    - dwell_cnt==0: if step_idx<L-1, then step_idx++ and -> ISSUE.
    - dwell_cnt==0 at the last entry: loop_en=1 -> step_idx<=0, ISSUE; loop_en=0 -> DONE.
    - Dwell value 0 therefore advances on the tick after arrival.
  - DONE (1 tick): done=1, busy<=0 -> IDLE. angle, speed and servo_en hold so the servo keeps its position.
  - FAULT (1 tick): fault<=1, speed<=0 (controller freezes), busy<=0 -> IDLE. fault is sticky until the next accepted start or rst.
- stop:
  - From any state other than IDLE: next state IDLE, speed<=0, busy<=0; angle and servo_en hold.
  - stop overrides start on the same tick and also overrides every other transition, including the DONE/FAULT exits.
- start while busy=1 is ignored; a held start after DONE restarts immediately on the next tick.
- Per-step latency: arrival is detected on the same tick the controller reaches tgt; entry N+1 reaches ISSUE dwell+1 ticks after arrival.
- loop_en and seq_len are sampled live. Lowering seq_len below step_idx+1 mid-run ends the sequence at the next step boundary, treating the current entry as the last.

Test Plan:
- Single step: entry0 = {90, 10, 0}, L=1, cur_pw modeled from 70 in +10 steps -> speed=10 and angle=90 on the tick after ISSUE; arrival at cur_pw=150 after 8 steps; done pulses exactly 1 tick; busy=0 afterwards; angle stays 90.
- Dwell and step order: entries {0,5,3} and {180,5,0}, L=2 -> DWELL lasts 4 ticks before entry 1 is issued; step_idx goes 0 -> 1; arrival at cur_pw=230.
- Loop: same two entries with loop_en=1 -> step_idx wraps 1 -> 0 with no done pulse; clearing loop_en ends the sequence after entry 1 with done=1.
- Stop mid-move: assert stop during MOVE -> next tick speed=0, busy=0, state IDLE, angle unchanged; start plus stop together -> stays IDLE.
- Timeout: MOVE_TIMEOUT=4, cur_pw stuck at 70, target angle 90 -> fault=1 on the 5th tick after ISSUE, speed=0; a new start clears fault.
- Write rules: wr {200, 15, 2} stores {180, 10, 2}; wr speed=0 stores 1; a write while busy=1 leaves memory unchanged (check by readback through playback).

Source files
------------

// File: rtl/servo_sequencer.sv
// Waypoint sequencer for one servo_controller: steps through programmed
// {angle, speed, dwell} entries, detecting arrival on the live pulsewidth.
module servo_sequencer #(
    parameter int DEPTH        = 16,
    parameter int MOVE_TIMEOUT = 255,
    parameter int MIN_PW       = 70,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic          rotation_clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [4:0]    seq_len,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_angle,
    input  logic [3:0]    wr_speed,
    input  logic [7:0]    wr_dwell,
    input  logic [11:0]   cur_pw,
    output logic [7:0]    angle,
    output logic [3:0]    speed,
    output logic          servo_en,
    output logic          busy,
    output logic [AW-1:0] step_idx,
    output logic          done,
    output logic          fault
);
    localparam int CW = $clog2(MOVE_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(MOVE_TIMEOUT - 1);

    typedef struct packed {
        logic [7:0] angle;
        logic [3:0] speed;
        logic [7:0] dwell;
    } waypoint_t;

    typedef enum logic [2:0] {IDLE, ISSUE, MOVE, DWELL, DONE, FAULT} state_t;

    waypoint_t mem [DEPTH];
    waypoint_t wr_ent, cur_ent;

    state_t        state, state_n;
    logic [7:0]    angle_n, dwell_cnt, dwell_n;
    logic [3:0]    speed_n;
    logic          en_n, busy_n, done_n, fault_n;
    logic [AW-1:0] step_n;
    logic [CW-1:0] move_cnt, move_n;
    logic [4:0]    eff_len;
    logic [5:0]    step_p1;
    logic          is_last;
    logic [11:0]   tgt;

    always_comb begin
        wr_ent.angle = (wr_angle > 8'd180) ? 8'd180 : wr_angle;
        wr_ent.speed = (wr_speed > 4'd10) ? 4'd10 :
                       (wr_speed == 4'd0) ? 4'd1 : wr_speed;
        wr_ent.dwell = wr_dwell;
    end

    // The table is frozen during playback so entries can be read combinationally.
    always_ff @(posedge rotation_clk) begin
        if (wr_en && !busy)
            mem[wr_addr] <= wr_ent;
    end

    assign cur_ent = mem[step_idx];
    assign tgt     = ({4'd0, angle} * 12'd8) / 12'd9 + 12'(MIN_PW);
    assign eff_len = (seq_len > 5'(DEPTH)) ? 5'(DEPTH) : seq_len;
    assign step_p1 = 6'(step_idx) + 6'd1;
    assign is_last = step_p1 >= {1'b0, eff_len};

    always_ff @(posedge rotation_clk) begin
        if (rst) begin
            state     <= IDLE;
            angle     <= '0;
            speed     <= '0;
            servo_en  <= 1'b0;
            busy      <= 1'b0;
            step_idx  <= '0;
            done      <= 1'b0;
            fault     <= 1'b0;
            move_cnt  <= '0;
            dwell_cnt <= '0;
        end else begin
            state     <= state_n;
            angle     <= angle_n;
            speed     <= speed_n;
            servo_en  <= en_n;
            busy      <= busy_n;
            step_idx  <= step_n;
            done      <= done_n;
            fault     <= fault_n;
            move_cnt  <= move_n;
            dwell_cnt <= dwell_n;
        end
    end

    always_comb begin
        state_n = state;
        angle_n = angle;
        speed_n = speed;
        en_n    = servo_en;
        busy_n  = busy;
        step_n  = step_idx;
        done_n  = 1'b0;
        fault_n = fault;
        move_n  = move_cnt;
        dwell_n = dwell_cnt;
        case (state)
            IDLE: begin
                if (start && !stop && eff_len != 5'd0) begin
                    state_n = ISSUE;
                    step_n  = '0;
                    busy_n  = 1'b1;
                    en_n    = 1'b1;
                    fault_n = 1'b0;
                end
            end
            ISSUE: begin
                angle_n = cur_ent.angle;
                speed_n = cur_ent.speed;
                move_n  = '0;
                state_n = MOVE;
            end
            MOVE: begin
                if (cur_pw == tgt) begin
                    dwell_n = cur_ent.dwell;
                    state_n = DWELL;
                end else if (move_cnt == TO_LAST) begin
                    state_n = FAULT;
                end else begin
                    move_n = move_cnt + CW'(1);
                end
            end
            DWELL: begin
                if (dwell_cnt != 8'd0) begin
                    dwell_n = dwell_cnt - 8'd1;
                end else if (!is_last) begin
                    step_n  = step_idx + AW'(1);
                    state_n = ISSUE;
                end else if (loop_en) begin
                    step_n  = '0;
                    state_n = ISSUE;
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            FAULT: begin
                fault_n = 1'b1;
                speed_n = '0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Abort wins over everything; the servo is frozen in place, not disabled.
        if (stop && state != IDLE) begin
            state_n = IDLE;
            angle_n = angle;
            speed_n = '0;
            en_n    = servo_en;
            busy_n  = 1'b0;
            step_n  = step_idx;
            done_n  = 1'b0;
            fault_n = fault;
        end
    end
endmodule

// File: tb/tb_servo_sequencer.sv
// Directed bench for servo_sequencer: write-rule/target table plus
// hand-timed sequences for dwell, loop, stop and move timeout.
module tb_servo_sequencer;
    logic        rotation_clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [4:0]  seq_len = 5'd1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_angle = '0, wr_dwell = '0;
    logic [3:0]  wr_speed = '0;
    logic [11:0] cur_pw = '0;

    logic [7:0] angle, angle_t;
    logic [3:0] speed, speed_t, step_idx, step_idx_t;
    logic       servo_en, busy, done, fault;
    logic       servo_en_t, busy_t, done_t, fault_t;

    int total = 0, bad = 0, done_seen = 0;

    servo_sequencer dut (
        .rotation_clk(rotation_clk), .rst(rst), .start(start), .stop(stop),
        .loop_en(loop_en), .seq_len(seq_len), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_angle(wr_angle), .wr_speed(wr_speed), .wr_dwell(wr_dwell), .cur_pw(cur_pw),
        .angle(angle), .speed(speed), .servo_en(servo_en), .busy(busy),
        .step_idx(step_idx), .done(done), .fault(fault)
    );

    servo_sequencer #(.MOVE_TIMEOUT(4)) dut_to (
        .rotation_clk(rotation_clk), .rst(rst), .start(start), .stop(stop),
        .loop_en(loop_en), .seq_len(seq_len), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_angle(wr_angle), .wr_speed(wr_speed), .wr_dwell(wr_dwell), .cur_pw(cur_pw),
        .angle(angle_t), .speed(speed_t), .servo_en(servo_en_t), .busy(busy_t),
        .step_idx(step_idx_t), .done(done_t), .fault(fault_t)
    );

    initial forever #5 rotation_clk = ~rotation_clk;

    typedef struct {
        logic [7:0]  wa;
        logic [3:0]  ws;
        logic [7:0]  ea;
        logic [3:0]  es;
        logic [11:0] et;
    } vec_t;
    vec_t vt [7];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rotation_clk);
            #1;
            if (done) done_seen++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic quiesce();
        start = 1'b0;
        stop  = 1'b1;
        tick(1);
        stop  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] ang,
                      input logic [3:0] spd, input logic [7:0] dw);
        wr_en = 1'b1; wr_addr = a; wr_angle = ang; wr_speed = spd; wr_dwell = dw;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        vt[0] = '{8'd200, 4'd15, 8'd180, 4'd10, 12'd230};
        vt[1] = '{8'd0,   4'd0,  8'd0,   4'd1,  12'd70};
        vt[2] = '{8'd90,  4'd10, 8'd90,  4'd10, 12'd150};
        vt[3] = '{8'd181, 4'd11, 8'd180, 4'd10, 12'd230};
        vt[4] = '{8'd10,  4'd3,  8'd10,  4'd3,  12'd78};
        vt[5] = '{8'd17,  4'd1,  8'd17,  4'd1,  12'd85};
        vt[6] = '{8'd1,   4'd7,  8'd1,   4'd7,  12'd70};

        tick(2);
        rst = 1'b0;
        chk("rst_angle", angle, 0);
        chk("rst_speed", speed, 0);
        chk("rst_en", servo_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_step", step_idx, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);

        // zero-length sequence must not start
        seq_len = 5'd0;
        go();
        chk("len0_busy", busy, 0);
        seq_len = 5'd1;

        // store clamping and target pulsewidth, one entry per vector
        for (int i = 0; i < 7; i++) begin
            quiesce();
            cur_pw = '0;
            wr(4'd0, vt[i].wa, vt[i].ws, 8'd0);
            go();
            tick(1);
            chk("tbl_angle", angle, vt[i].ea);
            chk("tbl_speed", speed, vt[i].es);
            cur_pw = vt[i].et - 12'd1;
            tick(2);
            chk("tbl_no_early", busy, 1);
            cur_pw = vt[i].et;
            tick(3);
            chk("tbl_arrive_done", done, 1);
        end

        // single step with a ramping pulsewidth
        quiesce();
        wr(4'd0, 8'd90, 4'd10, 8'd0);
        cur_pw = 12'd70;
        go();
        chk("ss_busy", busy, 1);
        chk("ss_en", servo_en, 1);
        tick(1);
        chk("ss_angle", angle, 90);
        chk("ss_speed", speed, 10);
        for (int k = 1; k <= 7; k++) begin
            cur_pw = 12'(70 + 10 * k);
            tick(1);
        end
        chk("ss_moving", busy, 1);
        cur_pw = 12'd150;
        tick(2);
        chk("ss_done_early", done, 0);
        tick(1);
        chk("ss_done", done, 1);
        chk("ss_idle", busy, 0);
        tick(1);
        chk("ss_done_width", done, 0);
        chk("ss_hold_angle", angle, 90);
        chk("ss_hold_en", servo_en, 1);

        // dwell and step order
        quiesce();
        wr(4'd0, 8'd0, 4'd5, 8'd3);
        wr(4'd1, 8'd180, 4'd5, 8'd0);
        seq_len = 5'd2;
        cur_pw = 12'd70;
        go();
        tick(1);
        chk("dw_angle0", angle, 0);
        tick(1);
        tick(3);
        chk("dw_still0", step_idx, 0);
        tick(1);
        chk("dw_step1", step_idx, 1);
        tick(1);
        chk("dw_angle1", angle, 180);
        cur_pw = 12'd230;
        tick(3);
        chk("dw_done", done, 1);

        // looped playback, then clear loop_en
        quiesce();
        loop_en = 1'b1;
        cur_pw = 12'd70;
        done_seen = 0;
        go();
        tick(6);
        tick(1);
        chk("lp_angle1", angle, 180);
        cur_pw = 12'd230;
        tick(2);
        chk("lp_wrap", step_idx, 0);
        chk("lp_busy", busy, 1);
        tick(1);
        chk("lp_angle0", angle, 0);
        cur_pw = 12'd70;
        tick(1);
        loop_en = 1'b0;
        tick(4);
        chk("lp_step1", step_idx, 1);
        tick(1);
        cur_pw = 12'd230;
        tick(1);
        chk("lp_no_done", done_seen, 0);
        tick(2);
        chk("lp_done", done, 1);
        chk("lp_idle", busy, 0);

        // stop mid-move, start+stop together, write while busy
        quiesce();
        seq_len = 5'd1;
        wr(4'd0, 8'd90, 4'd10, 8'd0);
        cur_pw = '0;
        go();
        tick(2);
        wr(4'd0, 8'd10, 4'd3, 8'd0);
        stop = 1'b1;
        tick(1);
        chk("st_speed", speed, 0);
        chk("st_busy", busy, 0);
        chk("st_angle", angle, 90);
        chk("st_en", servo_en, 1);
        start = 1'b1;
        tick(1);
        chk("st_startstop", busy, 0);
        stop = 1'b0;
        tick(1);
        start = 1'b0;
        tick(1);
        chk("wr_busy_angle", angle, 90);
        chk("wr_busy_speed", speed, 10);

        // move timeout on the short-timeout instance
        quiesce();
        cur_pw = 12'd70;
        go();
        chk("to_clear0", fault_t, 0);
        tick(5);
        chk("to_not_yet", fault_t, 0);
        tick(1);
        chk("to_fault", fault_t, 1);
        chk("to_speed", speed_t, 0);
        chk("to_busy", busy_t, 0);
        quiesce();
        chk("to_sticky", fault_t, 1);
        go();
        chk("to_restart_clr", fault_t, 0);
        quiesce();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
